pio_stream_source: RTL and testbench
====================================

PIO_STREAM_SOURCE -- requirements
Module: pio_stream_source

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 13'h0000, meaning the PIO word address of register 0; registers occupy ADDR_BASE+0..ADDR_BASE+4.
REQ-002 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pio_write_valid, input, 1, meaning a PIO write strobe qualifying pio_address/pio_write_data.
REQ-005 SHALL have port pio_read_valid, input, 1, meaning a PIO read request qualifying pio_address.
REQ-006 SHALL have port pio_address, input, 13, meaning the PIO word address.
REQ-007 SHALL have port pio_write_data, input, 64, meaning the PIO write data.
REQ-008 SHALL have port pio_read_data, output, 64, meaning the read response data.
REQ-009 SHALL have port pio_read_data_valid, output, 1, meaning a one-cycle response strobe.
REQ-010 SHALL have port fifo_to_pc_data, output, 64, meaning the stream word.
REQ-011 SHALL have port fifo_to_pc_write, output, 1, meaning the stream write strobe.
REQ-012 SHALL have port fifo_to_pc_almost_full, input, 1, meaning stream backpressure.

Function
REQ-013 SHALL decode reg0 CTRL (bit0 enable, bit1 mode: 0 counter, 1 LFSR), reg1 COUNT (32b, 0 = continuous), reg2 SEED (64b), reg3 SENT (32b, read-only), reg4 SCRATCH (64b); writes outside ADDR_BASE+0..4, and writes to reg3, SHALL be ignored.
REQ-014 SHALL assert pio_read_data_valid exactly 1 cycle after each pio_read_valid cycle, with pio_read_data = addressed register zero-extended; unmapped addresses return 0; back-to-back reads each get one response.
REQ-015 SHALL hold pio_read_data at its last value when pio_read_data_valid is low.
REQ-016 SHALL implement FSM IDLE, RUN, DONE: IDLE->RUN on a CTRL write with bit0=1; RUN->DONE when SENT equals a nonzero COUNT; RUN or DONE->IDLE on a CTRL write with bit0=0.
REQ-017 SHALL, on IDLE->RUN, load the generator with SEED (LFSR mode: SEED of 0 replaced by 1) and clear SENT to 0.
REQ-018 SHALL, in RUN, register a write (fifo_to_pc_write=1 in cycle N+1) for every cycle N in which fifo_to_pc_almost_full=0 and the count is not yet reached, otherwise fifo_to_pc_write=0 in N+1.
REQ-019 SHALL increment SENT and advance the generator on each issued write; counter mode = previous+1 modulo 2^64; LFSR mode = 64-bit Fibonacci, polynomial x^64+x^63+x^61+x^60+1, shift left, feedback into bit0.
REQ-020 SHALL never issue more than COUNT writes for a nonzero COUNT, including when COUNT is written below SENT mid-run (immediate DONE).
REQ-021 SHALL wrap SENT modulo 2^32 in continuous mode.
REQ-022 SHALL let COUNT/SEED/mode writes during RUN update the registers; mode and SEED take effect only at the next start, while COUNT takes effect immediately.
REQ-023 SHALL give a CTRL write precedence over a same-cycle count-reached condition, and serve a same-cycle read and write to one register with the pre-write value.
REQ-024 SHALL keep fifo_to_pc_write=0 in IDLE and DONE.

Reset
REQ-025 SHALL, on reset, force FSM IDLE, all registers, SENT, and the generator to 0, pio_read_data_valid=0, pio_read_data=0, fifo_to_pc_write=0, and fifo_to_pc_data=0.
REQ-026 SHALL abort a run immediately on reset mid-run and drop any pending read response.

Configuration
REQ-027 SHALL, with PIO_STREAM_SOURCE_LFSR_EN defined, provide LFSR mode per REQ-019; without it, omit LFSR logic, ignore CTRL bit1, read CTRL bit1 as 0, and support counter mode only.

Verification
REQ-028 SHALL cover: SEED=5, COUNT=4, CTRL=1, almost_full=0 -> data 5,6,7,8 on 4 consecutive writes, then DONE, SENT reads 4.
REQ-029 SHALL cover: almost_full held high for 10 cycles mid-run -> no write within 1 cycle after it rises, and resumption 1 cycle after it falls with no skipped or duplicated values.
REQ-030 SHALL cover: read ADDR_BASE+4 after SCRATCH=0xDEADBEEF, then read ADDR_BASE+7 -> valid exactly 1 cycle after each request, data 0xDEADBEEF then 0.
REQ-031 SHALL cover: with LFSR_EN, SEED=0, mode=1, COUNT=2 -> data 1, then 2 (0x1 shifted left, feedback 0).
REQ-032 SHALL cover: COUNT=0 run, CTRL=0 written after 100 writes -> writes stop within 1 cycle, SENT=100.
REQ-033 SHALL cover: reset asserted mid-run -> next cycle has write=0, valid=0, SENT reads 0.

Source files
------------

// File: rtl/pio_stream_source.sv
// PIO-programmed stream source: counter words, or LFSR words when PIO_STREAM_SOURCE_LFSR_EN is defined.
// PIO reads answer one cycle after the request; stream writes follow the deciding cycle by one and stall on almost_full.
module pio_stream_source #(
  parameter logic [12:0] ADDR_BASE = 13'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_write_valid,
  input  logic        pio_read_valid,
  input  logic [12:0] pio_address,
  input  logic [63:0] pio_write_data,
  output logic [63:0] pio_read_data,
  output logic        pio_read_data_valid,
  output logic [63:0] fifo_to_pc_data,
  output logic        fifo_to_pc_write,
  input  logic        fifo_to_pc_almost_full
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state;
  logic        ctrl_enable;
  logic        ctrl_mode;
  logic [31:0] count_reg;
  logic [63:0] seed_reg;
  logic [31:0] sent;
  logic [63:0] scratch_reg;
  logic [63:0] gen;

  logic [13:0] rel_addr;
  logic        reg_hit;
  logic [2:0]  reg_idx;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_seed;
  logic        wr_scratch;
  logic        mode_in;
  logic        start_req;
  logic        stop_req;
  logic        count_hit;
  logic        issue;
  logic [63:0] gen_next;
  logic [63:0] start_value;
  logic [63:0] rd_value;

  // One extra bit catches addresses below ADDR_BASE as a borrow.
  assign rel_addr   = {1'b0, pio_address} - {1'b0, ADDR_BASE};
  assign reg_hit    = !rel_addr[13] && (rel_addr[12:0] < 13'd5);
  assign reg_idx    = rel_addr[2:0];

  assign wr_ctrl    = pio_write_valid && reg_hit && (reg_idx == 3'd0);
  assign wr_count   = pio_write_valid && reg_hit && (reg_idx == 3'd1);
  assign wr_seed    = pio_write_valid && reg_hit && (reg_idx == 3'd2);
  assign wr_scratch = pio_write_valid && reg_hit && (reg_idx == 3'd4);

  assign start_req  = (state == ST_IDLE) && wr_ctrl && pio_write_data[0];
  assign stop_req   = wr_ctrl && !pio_write_data[0];
  assign count_hit  = (count_reg != 32'd0) && (sent >= count_reg);
  assign issue      = (state == ST_RUN) && !fifo_to_pc_almost_full && !count_hit && !stop_req;

`ifdef PIO_STREAM_SOURCE_LFSR_EN
  logic run_lfsr;
  logic feedback;

  assign mode_in     = pio_write_data[1];
  assign feedback    = gen[63] ^ gen[62] ^ gen[60] ^ gen[59];
  assign gen_next    = run_lfsr ? {gen[62:0], feedback} : gen + 64'd1;
  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign start_value = (mode_in && (seed_reg == 64'd0)) ? 64'd1 : seed_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      run_lfsr <= 1'b0;
    end else if (start_req) begin
      run_lfsr <= mode_in;
    end
  end
`else
  assign mode_in     = 1'b0;
  assign gen_next    = gen + 64'd1;
  assign start_value = seed_reg;
`endif

  always_comb begin
    rd_value = 64'd0;
    if (reg_hit) begin
      case (reg_idx)
        3'd0:    rd_value = {62'd0, ctrl_mode, ctrl_enable};
        3'd1:    rd_value = {32'd0, count_reg};
        3'd2:    rd_value = seed_reg;
        3'd3:    rd_value = {32'd0, sent};
        3'd4:    rd_value = scratch_reg;
        default: rd_value = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_IDLE;
      ctrl_enable         <= 1'b0;
      ctrl_mode           <= 1'b0;
      count_reg           <= 32'd0;
      seed_reg            <= 64'd0;
      sent                <= 32'd0;
      scratch_reg         <= 64'd0;
      gen                 <= 64'd0;
      pio_read_data       <= 64'd0;
      pio_read_data_valid <= 1'b0;
      fifo_to_pc_data     <= 64'd0;
      fifo_to_pc_write    <= 1'b0;
    end else begin
      // Reads sample the registers before this cycle's write lands.
      pio_read_data_valid <= pio_read_valid;
      if (pio_read_valid) begin
        pio_read_data <= rd_value;
      end

      if (wr_ctrl) begin
        ctrl_enable <= pio_write_data[0];
        ctrl_mode   <= mode_in;
      end
      if (wr_count) begin
        count_reg <= pio_write_data[31:0];
      end
      if (wr_seed) begin
        seed_reg <= pio_write_data;
      end
      if (wr_scratch) begin
        scratch_reg <= pio_write_data;
      end

      fifo_to_pc_write <= 1'b0;
      if (issue) begin
        fifo_to_pc_write <= 1'b1;
        fifo_to_pc_data  <= gen;
        gen              <= gen_next;
        sent             <= sent + 32'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_RUN;
            gen   <= start_value;
            sent  <= 32'd0;
          end
        end
        ST_RUN: begin
          // A CTRL write wins over a count reached in the same cycle.
          if (wr_ctrl) begin
            if (!pio_write_data[0]) begin
              state <= ST_IDLE;
            end
          end else if (count_hit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (stop_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_stream_source.sv
// Bench for pio_stream_source: queue-based model of the expected word stream plus directed register/FSM scenarios.
`timescale 1ns/1ps
module tb_pio_stream_source;

  localparam logic [12:0] BASE = 13'h0100;
`ifdef PIO_STREAM_SOURCE_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif
  localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        pio_write_valid;
  logic        pio_read_valid;
  logic [12:0] pio_address;
  logic [63:0] pio_write_data;
  logic [63:0] pio_read_data;
  logic        pio_read_data_valid;
  logic [63:0] fifo_to_pc_data;
  logic        fifo_to_pc_write;
  logic        fifo_to_pc_almost_full;

  pio_stream_source #(.ADDR_BASE(BASE)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .pio_write_valid        (pio_write_valid),
    .pio_read_valid         (pio_read_valid),
    .pio_address            (pio_address),
    .pio_write_data         (pio_write_data),
    .pio_read_data          (pio_read_data),
    .pio_read_data_valid    (pio_read_data_valid),
    .fifo_to_pc_data        (fifo_to_pc_data),
    .fifo_to_pc_write       (fifo_to_pc_write),
    .fifo_to_pc_almost_full (fifo_to_pc_almost_full)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic        mon_en = 1'b0;
  logic        af_prev = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_next(input logic [63:0] v, input bit lfsr);
    if (lfsr) return {v[62:0], ^(v & TAP_MASK)};
    return v + 64'd1;
  endfunction

  always @(posedge clock) cyc++;

  // Every stream word must match the model queue and follow a cycle with almost_full low.
  always @(negedge clock) begin
    if (mon_en && fifo_to_pc_write === 1'b1) begin
      wr_seen++;
      if (wr_seen == 1) first_cyc = cyc;
      last_cyc = cyc;
      check("wr_after_af", 64'(af_prev), 64'd0);
      if (exp_q.size() == 0) check("extra_wr", 64'd1, 64'd0);
      else check("wr_dat", fifo_to_pc_data, exp_q.pop_front());
    end
    af_prev = fifo_to_pc_almost_full;
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pio_write(input logic [12:0] a, input logic [63:0] d);
    pio_write_valid = 1'b1;
    pio_address     = a;
    pio_write_data  = d;
    cycle();
    pio_write_valid = 1'b0;
  endtask

  task automatic pio_read(input logic [12:0] a, output logic [63:0] d);
    pio_read_valid = 1'b1;
    pio_address    = a;
    cycle();
    pio_read_valid = 1'b0;
    check("rd_vld", 64'(pio_read_data_valid), 64'd1);
    d = pio_read_data;
  endtask

  task automatic start_run(input logic [63:0] seed, input logic [31:0] cnt, input bit mode);
    logic [63:0] v;
    bit          lfsr;
    int          n;
    lfsr = mode && LFSR_EN;
    pio_write(BASE + 13'd2, seed);
    pio_write(BASE + 13'd1, {32'd0, cnt});
    v = (lfsr && seed == 64'd0) ? 64'd1 : seed;
    n = (cnt == 32'd0) ? 400 : int'(cnt);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = model_next(v, lfsr);
    end
    wr_seen = 0;
    pio_write(BASE, {62'd0, mode, 1'b1});
  endtask

  task automatic stop_run();
    pio_write(BASE, 64'd0);
    repeat (2) cycle();
    exp_q.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (wr_seen < n && c < budget) begin
      cycle();
      c++;
    end
    if (wr_seen < n) check(tag, 64'(wr_seen), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] seed;
    int          cnt;
    bit          mode;

    reset = 1'b1;
    pio_write_valid = 1'b0;
    pio_read_valid = 1'b0;
    pio_address = 13'd0;
    pio_write_data = 64'd0;
    fifo_to_pc_almost_full = 1'b0;
    repeat (3) cycle();
    check("rst_wr", 64'(fifo_to_pc_write), 64'd0);
    check("rst_vld", 64'(pio_read_data_valid), 64'd0);
    check("rst_rdat", pio_read_data, 64'd0);
    check("rst_fdat", fifo_to_pc_data, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      pio_read(BASE + 13'(i), rd);
      check("rst_reg", rd, 64'd0);
    end

    // COUNT is 32 bits wide and reads back zero-extended.
    pio_write(BASE + 13'd1, 64'hFFFF_FFFF_1234_5678);
    pio_read(BASE + 13'd1, rd);
    check("count_zext", rd, 64'h0000_0000_1234_5678);

    // SEED=5 COUNT=4: words 5..8 back to back, then DONE.
    start_run(64'd5, 32'd4, 1'b0);
    wait_writes(4, 50, "basic_timeout");
    repeat (5) cycle();
    check("basic_cnt", 64'(wr_seen), 64'd4);
    check("basic_consec", 64'(last_cyc - first_cyc), 64'd3);
    check("basic_q", 64'(exp_q.size()), 64'd0);
    pio_read(BASE + 13'd3, rd);
    check("basic_sent", rd, 64'd4);
    pio_write(BASE + 13'd3, 64'd99);
    pio_read(BASE + 13'd3, rd);
    check("sent_ro", rd, 64'd4);
    stop_run();

    // Ten cycles of backpressure mid-run.
    start_run({$urandom(), $urandom()}, 32'd30, 1'b0);
    repeat (5) cycle();
    fifo_to_pc_almost_full = 1'b1;
    cycle();
    check("af_stop", 64'(fifo_to_pc_write), 64'd0);
    repeat (9) cycle();
    fifo_to_pc_almost_full = 1'b0;
    cycle();
    check("af_resume", 64'(fifo_to_pc_write), 64'd1);
    wait_writes(30, 100, "af_timeout");
    repeat (3) cycle();
    check("af_cnt", 64'(wr_seen), 64'd30);
    pio_read(BASE + 13'd3, rd);
    check("af_sent", rd, 64'd30);
    stop_run();

    // Randomized runs; the first seed exercises the 64-bit counter wrap.
    for (int it = 0; it < 8; it++) begin
      seed = (it == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom(), $urandom()};
      if (it == 1) seed = 64'd0;
      cnt  = $urandom_range(1, 40);
      mode = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      start_run(seed, 32'(cnt), mode);
      // Mode and SEED written mid-run must not disturb the running stream.
      pio_write(BASE + 13'd2, {$urandom(), $urandom()});
      pio_write(BASE, {62'd0, ~mode, 1'b1});
      pio_read(BASE, rd);
      check("rand_ctrl", rd, {62'd0, (~mode) & LFSR_EN, 1'b1});
      for (int c = 0; c < 1000 && wr_seen < cnt; c++) begin
        fifo_to_pc_almost_full = ($urandom_range(0, 99) < 30);
        cycle();
      end
      fifo_to_pc_almost_full = 1'b0;
      if (wr_seen < cnt) check("rand_timeout", 64'(wr_seen), 64'(cnt));
      repeat (5) cycle();
      check("rand_cnt", 64'(wr_seen), 64'(cnt));
      pio_read(BASE + 13'd3, rd);
      check("rand_sent", rd, 64'(cnt));
      stop_run();
    end

    // COUNT lowered below SENT mid-run stops the stream at once.
    start_run({$urandom(), $urandom()}, 32'd50, 1'b0);
    repeat (20) cycle();
    fifo_to_pc_almost_full = 1'b1;
    pio_write(BASE + 13'd1, 64'd5);
    fifo_to_pc_almost_full = 1'b0;
    repeat (10) cycle();
    check("shrink_cnt", 64'(wr_seen), 64'd20);
    check("shrink_wr", 64'(fifo_to_pc_write), 64'd0);
    pio_read(BASE + 13'd3, rd);
    check("shrink_sent", rd, 64'd20);
    stop_run();

    // Zero seed in LFSR mode yields 1 then 2; counter-only builds yield 0 then 1.
    pio_write(BASE + 13'd2, 64'd0);
    pio_write(BASE + 13'd1, 64'd2);
    exp_q.delete();
    exp_q.push_back(LFSR_EN ? 64'd1 : 64'd0);
    exp_q.push_back(LFSR_EN ? 64'd2 : 64'd1);
    wr_seen = 0;
    pio_write(BASE, 64'd3);
    wait_writes(2, 50, "lfsr_timeout");
    repeat (5) cycle();
    check("lfsr_cnt", 64'(wr_seen), 64'd2);
    pio_read(BASE, rd);
    check("lfsr_ctrl", rd, LFSR_EN ? 64'd3 : 64'd1);
    stop_run();

    // Continuous run stopped after exactly 100 words.
    start_run({$urandom(), $urandom()}, 32'd0, 1'b0);
    repeat (100) cycle();
    fifo_to_pc_almost_full = 1'b1;
    pio_write(BASE, 64'd0);
    check("cont_stop_wr", 64'(fifo_to_pc_write), 64'd0);
    fifo_to_pc_almost_full = 1'b0;
    repeat (5) cycle();
    check("cont_cnt", 64'(wr_seen), 64'd100);
    pio_read(BASE + 13'd3, rd);
    check("cont_sent", rd, 64'd100);
    exp_q.delete();

    // Register read timing, unmapped reads, hold, write-range and read/write collision.
    pio_write(BASE + 13'd4, 64'hDEAD_BEEF);
    pio_read(BASE + 13'd4, rd);
    check("rd_scratch", rd, 64'hDEAD_BEEF);
    pio_read(BASE + 13'd7, rd);
    check("rd_unmapped", rd, 64'd0);
    cycle();
    check("rd_vld_low", 64'(pio_read_data_valid), 64'd0);
    pio_read(BASE + 13'd4, rd);
    cycle();
    check("rd_hold", pio_read_data, 64'hDEAD_BEEF);
    pio_write(BASE + 13'd5, 64'h1111);
    pio_write(BASE - 13'd1, 64'h2222);
    pio_read(BASE + 13'd4, rd);
    check("wr_outside", rd, 64'hDEAD_BEEF);
    pio_write_valid = 1'b1;
    pio_read_valid  = 1'b1;
    pio_address     = BASE + 13'd4;
    pio_write_data  = 64'h1234;
    cycle();
    pio_write_valid = 1'b0;
    pio_read_valid  = 1'b0;
    check("rw_same_vld", 64'(pio_read_data_valid), 64'd1);
    check("rw_same_old", pio_read_data, 64'hDEAD_BEEF);
    pio_read(BASE + 13'd4, rd);
    check("rw_same_new", rd, 64'h1234);

    // Reset mid-run with a read pending.
    start_run({$urandom(), $urandom()}, 32'd0, 1'b0);
    repeat (20) cycle();
    reset = 1'b1;
    pio_read_valid = 1'b1;
    pio_address = BASE + 13'd3;
    cycle();
    pio_read_valid = 1'b0;
    check("rst_run_wr", 64'(fifo_to_pc_write), 64'd0);
    check("rst_run_vld", 64'(pio_read_data_valid), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    cycle();
    pio_read(BASE + 13'd3, rd);
    check("rst_run_sent", rd, 64'd0);
    pio_read(BASE + 13'd4, rd);
    check("rst_run_scratch", rd, 64'd0);
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
